truth_table_sequencer: RTL and testbench

- Self-checking stimulus controller for a 4-input, 2-output combinational unit (inputs a,b,c,d; outputs f,g).
- On start, drives all 2^N_IN input vectors in ascending order and holds each for a settling dwell.
- Samples the unit's response for each vector and compares it against a parameterised expected truth table.
- Reports error count, first failing vector and a pass flag; sits beside the unit in bring-up and regression fabrics.

---
 rtl/truth_table_sequencer_pkg.sv | 36 +++
 rtl/truth_table_sequencer_compare.sv | 28 ++
 rtl/truth_table_sequencer.sv | 169 ++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer.
//   state_t      : sequencer FSM state encoding
//   NUM_VEC      : number of input vectors for the default 4-input unit
//   table_entry(): returns entry idx (n_out bits wide) of a packed truth table
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_IN_DEF  = 4;
    localparam int N_OUT_DEF = 2;
    localparam int NUM_VEC   = 2 ** N_IN_DEF;

    // Upper bounds for the generic table helper; callers zero-extend into these.
    localparam int TBL_MAX_W = 1024;
    localparam int OUT_MAX_W = 16;

    // Entry idx of a packed table with n_out bits per entry, zero-extended.
    function automatic logic [OUT_MAX_W-1:0] table_entry(
        input logic [TBL_MAX_W-1:0] tbl,
        input int unsigned          idx,
        input int unsigned          n_out
    );
        logic [TBL_MAX_W-1:0] shifted;
        logic [OUT_MAX_W-1:0] mask;
        shifted = tbl >> (idx * n_out);
        // n_out == OUT_MAX_W wraps the shift to zero, so the mask becomes all ones.
        mask    = (OUT_MAX_W'(1) << n_out) - OUT_MAX_W'(1);
        return shifted[OUT_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_compare.sv
// Combinational expected-response lookup and mismatch detection.
// Ports:
//   vec      in  N_IN   vector currently applied to the unit
//   resp     in  N_OUT  response returned by the unit
//   mismatch out 1      any bit of resp differs from EXP_TABLE[vec]
module truth_table_sequencer_compare
    import truth_table_sequencer_pkg::*;
#(
    parameter int                           N_IN      = 4,
    parameter int                           N_OUT     = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0]   EXP_TABLE = '0
) (
    input  logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] resp,
    output logic             mismatch
);

    localparam logic [TBL_MAX_W-1:0] TBL_EXT = TBL_MAX_W'(EXP_TABLE);

    logic [OUT_MAX_W-1:0] expected;

    always_comb begin
        expected = table_entry(TBL_EXT, 32'(vec), N_OUT);
        // Compare at full helper width; upper bits of expected are zero.
        mismatch = (expected != OUT_MAX_W'(resp));
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Stimulus/check controller for a small combinational unit: sweeps all
// input vectors in ascending order, holds each for DWELL cycles, samples the
// response and compares it with EXP_TABLE.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             launch a sweep (IDLE only)
//   abort             stop a running sweep, no done pulse
//   resp              response from the unit ({f,g})
//   vec               stimulus to the unit ({a,b,c,d})
//   busy              high in APPLY and SAMPLE
//   done              one-cycle pulse at the end of a completed sweep
//   pass              last completed sweep had no mismatches
//   err_count         mismatching vectors in current/last sweep
//   first_fail_valid  a mismatch has been seen in current/last sweep
//   first_fail_idx    index of the first mismatching vector
//
// state  | meaning
// IDLE   | waiting for start
// APPLY  | vec driven, waiting DWELL cycles for the unit to settle
// SAMPLE | resp compared against the table, advance or finish
// DONE   | one-cycle completion, done pulse and pass update
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int                           N_IN      = 4,
    parameter int                           N_OUT     = 2,
    parameter int                           DWELL     = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0]   EXP_TABLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_idx
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t          state, state_d;
    logic [DCW-1:0]  dwell_cnt, dwell_d;
    logic [N_IN-1:0] vec_d;
    logic            busy_d, done_d, pass_d;
    logic [N_IN:0]   err_d;
    logic            ffv_d;
    logic [N_IN-1:0] ffi_d;
    logic            mismatch;

    truth_table_sequencer_compare #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .EXP_TABLE (EXP_TABLE)
    ) u_compare (
        .vec      (vec),
        .resp     (resp),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            dwell_cnt        <= '0;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            state            <= state_d;
            dwell_cnt        <= dwell_d;
            vec              <= vec_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail_valid <= ffv_d;
            first_fail_idx   <= ffi_d;
        end
    end

    always_comb begin
        state_d = state;
        dwell_d = dwell_cnt;
        vec_d   = vec;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_count;
        ffv_d   = first_fail_valid;
        ffi_d   = first_fail_idx;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    vec_d   = '0;
                    dwell_d = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffi_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    dwell_d = '0;
                end else if (dwell_cnt == DCW'(DWELL - 1)) begin
                    state_d = ST_SAMPLE;
                    dwell_d = '0;
                    busy_d  = 1'b1;
                end else begin
                    dwell_d = dwell_cnt + DCW'(1);
                    busy_d  = 1'b1;
                end
            end

            ST_SAMPLE: begin
                // Abort takes priority over the final sample, so no done pulse.
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    dwell_d = '0;
                end else begin
                    if (mismatch) begin
                        err_d = err_count + (N_IN+1)'(1);
                        if (!first_fail_valid) begin
                            ffv_d = 1'b1;
                            ffi_d = vec;
                        end
                    end
                    if (&vec) begin
                        state_d = ST_DONE;
                        vec_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = ST_APPLY;
                        vec_d   = vec + N_IN'(1);
                        dwell_d = '0;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    // Reference unit: f = (a & b) | (c ^ d), g = a ^ b ^ c ^ d
    function automatic logic [1:0] gold(input logic [3:0] v);
        logic f, g;
        f = (v[3] & v[2]) | (v[1] ^ v[0]);
        g = ^v;
        return {f, g};
    endfunction

    function automatic logic [31:0] build_tbl();
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[i*2 +: 2] = gold(4'(i));
        return t;
    endfunction

    localparam logic [31:0] GOLD_TBL = build_tbl();

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  resp;
    logic [3:0]  vec;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic        ffv;
    logic [3:0]  ffi;
    logic [15:0] fault_mask = '0;

    logic        start_z = 1'b0;
    logic        abort_z = 1'b0;
    logic [1:0]  resp_z;
    logic [3:0]  vec_z;
    logic        busy_z, done_z, pass_z;
    logic [4:0]  err_z;
    logic        ffv_z;
    logic [3:0]  ffi_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Unit model with optional injected faults on g.
    always_comb resp = gold(vec) ^ {1'b0, fault_mask[vec]};
    assign resp_z = 2'b01;

    truth_table_sequencer #(.N_IN(4), .N_OUT(2), .DWELL(2), .EXP_TABLE(GOLD_TBL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .resp(resp),
        .vec(vec), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(ffv), .first_fail_idx(ffi)
    );

    truth_table_sequencer #(.N_IN(4), .N_OUT(2), .DWELL(2)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .abort(abort_z), .resp(resp_z),
        .vec(vec_z), .busy(busy_z), .done(done_z), .pass(pass_z), .err_count(err_z),
        .first_fail_valid(ffv_z), .first_fail_idx(ffi_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start; on return we are at cycle 1 (first cycle after the start edge).
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] mask;
        int          restart_at;
        int          exp_err;
        bit          exp_ffv;
        int          exp_ffi;
        bit          exp_pass;
    } sweep_vec_t;

    task automatic run_sweep(input sweep_vec_t sv, input string tag);
        fault_mask = sv.mask;
        launch();
        for (int cyc = 1; cyc <= 49; cyc++) begin
            if (cyc <= 48)
                chk({tag, ":step"}, {29'd0, busy, done, 1'b0} | (32'(vec) << 3),
                    {29'd0, 1'b1, 1'b0, 1'b0} | (32'((cyc - 1) / 3) << 3));
            else begin
                chk({tag, ":done"}, {28'd0, vec, busy, done}, {28'd0, 4'd0, 1'b0, 1'b1});
                chk({tag, ":err_count"}, 32'(err_count), 32'(sv.exp_err));
                chk({tag, ":ffv"}, 32'(ffv), 32'(sv.exp_ffv));
                if (sv.exp_ffv) chk({tag, ":ffi"}, 32'(ffi), 32'(sv.exp_ffi));
                chk({tag, ":pass"}, 32'(pass), 32'(sv.exp_pass));
            end
            start = (cyc == sv.restart_at);
            step();
        end
        start = 1'b0;
        chk({tag, ":after_done"}, {30'd0, busy, done}, 32'd0);
        fault_mask = '0;
    endtask

    task automatic run_abort(input int abort_at, input string tag);
        bit saw_done;
        saw_done = 1'b0;
        fault_mask = '0;
        launch();
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == abort_at) chk({tag, ":busy_before"}, 32'(busy), 32'd1);
            if (cyc == abort_at + 1) chk({tag, ":idle_after"}, {27'd0, busy, vec}, 32'd0);
            saw_done |= done;
            abort = (cyc == abort_at);
            step();
        end
        abort = 1'b0;
        chk({tag, ":no_done"}, 32'(saw_done), 32'd0);
        chk({tag, ":pass"}, 32'(pass), 32'd0);
    endtask

    sweep_vec_t tbl[$];

    initial begin
        int first_done, second_done, dz;

        // f,g fault patterns with hand-computed outcomes.
        //          mask       restart exp_err ffv ffi pass
        tbl.push_back('{16'h0000, 10,  0, 1'b0,  0, 1'b1});
        tbl.push_back('{16'h0020,  0,  1, 1'b1,  5, 1'b0});
        tbl.push_back('{16'h0001, 49,  1, 1'b1,  0, 1'b0});
        tbl.push_back('{16'h8000,  0,  1, 1'b1, 15, 1'b0});
        tbl.push_back('{16'h0280, 30,  2, 1'b1,  7, 1'b0});
        tbl.push_back('{16'hFFFF,  0, 16, 1'b1,  0, 1'b0});
        tbl.push_back('{16'h0000,  0,  0, 1'b0,  0, 1'b1});

        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {15'd0, vec, busy, done, pass, err_count, ffv, ffi}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++)
            run_sweep(tbl[i], $sformatf("sweep%0d", i));

        // Always-wrong responses against an all-zero table.
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        dz = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (done_z && dz == 0) dz = cyc;
            step();
        end
        chk("zero_tbl:done_cycle", 32'(dz), 32'd49);
        chk("zero_tbl:err_count", 32'(err_z), 32'd16);
        chk("zero_tbl:ffv", 32'(ffv_z), 32'd1);
        chk("zero_tbl:ffi", 32'(ffi_z), 32'd0);
        chk("zero_tbl:pass", 32'(pass_z), 32'd0);

        run_abort(20, "abort_apply");
        run_abort(48, "abort_last_sample");

        // Start and abort together in IDLE: start wins; then abort in APPLY.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        chk("start_beats_abort", {27'd0, busy, vec}, {27'd0, 1'b1, 4'd0});
        step();
        abort = 1'b0;
        chk("abort_in_apply", 32'(busy), 32'd0);
        step();

        // Reset mid-sweep clears everything without a clock edge.
        fault_mask = 16'h0004;
        launch();
        for (int cyc = 1; cyc < 30; cyc++) step();
        chk("pre_reset_ffv", 32'(ffv), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {15'd0, vec, busy, done, pass, err_count, ffv, ffi}, 32'd0);
        fault_mask = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep('{16'h0000, 0, 0, 1'b0, 0, 1'b1}, "after_reset");

        // Start held high across two back-to-back sweeps.
        fault_mask = 16'h0020;
        first_done = 0;
        second_done = 0;
        start = 1'b1;
        step();
        for (int cyc = 1; cyc <= 99; cyc++) begin
            if (done) begin
                if (first_done == 0) first_done = cyc;
                else if (second_done == 0) second_done = cyc;
            end
            if (cyc == 49) begin
                chk("held:first_err", 32'(err_count), 32'd1);
                chk("held:first_pass", 32'(pass), 32'd0);
            end
            if (cyc == 50) fault_mask = '0;
            if (cyc == 51) chk("held:err_cleared", {26'd0, busy, err_count}, {26'd0, 1'b1, 5'd0});
            if (cyc == 99) begin
                chk("held:second_pass", 32'(pass), 32'd1);
                start = 1'b0;
            end
            step();
        end
        chk("held:first_done", 32'(first_done), 32'd49);
        chk("held:gap", 32'(second_done - first_done), 32'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
